// File: rtl/rob_pkg.sv
// Shared types and default sizes for the reorder buffer: entry layout,
// tag type and the registered retire bundle.
package rob_pkg;

  localparam int ROB_DEPTH = 16;
  localparam int ROB_IDX_W = $clog2(ROB_DEPTH);
  localparam int ROB_XLEN  = 32;

  typedef logic [ROB_IDX_W-1:0] rob_tag_t;

  typedef struct packed {
    logic                busy;
    logic                done;
    logic                has_rd;
    logic [4:0]          rd;
    logic [ROB_XLEN-1:0] value;
    logic [ROB_XLEN-1:0] pc;
  } rob_entry_t;

  typedef struct packed {
    logic [1:0]                valid;
    logic [1:0]                has_rd;
    logic [1:0][4:0]           rd;
    logic [1:0][ROB_XLEN-1:0] value;
    logic [1:0][ROB_XLEN-1:0] pc;
  } commit_t;

endpackage

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: 2-wide in-order dispatch, out-of-order CDB
// completion, 2-wide in-order retire and a full synchronous flush.
module reorder_buffer
  import rob_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  parameter int IDX_W = $clog2(DEPTH),
  parameter int XLEN  = ROB_XLEN
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            disp_valid,
  input  logic [1:0]            disp_has_rd,
  input  logic [1:0][4:0]       disp_rd,
  input  logic [1:0][XLEN-1:0]  disp_pc,
  output logic                  disp_ready,
  output logic [1:0][IDX_W-1:0] disp_tag,
  input  logic [1:0]            cdb_valid,
  input  logic [1:0][IDX_W-1:0] cdb_tag,
  input  logic [1:0][XLEN-1:0]  cdb_value,
  input  logic                  flush,
  output logic [1:0]            commit_valid,
  output logic [1:0]            commit_has_rd,
  output logic [1:0][4:0]       commit_rd,
  output logic [1:0][XLEN-1:0]  commit_value,
  output logic [1:0][XLEN-1:0]  commit_pc,
  output logic [IDX_W:0]        count,
  output logic                  empty,
  output logic                  full
);

  localparam logic [IDX_W:0] READY_MAX = (IDX_W+1)'(DEPTH - 2);
  localparam logic [IDX_W:0] FULL_CNT  = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0] TWO       = (IDX_W+1)'(2);

  rob_entry_t mem_q [DEPTH];
  rob_entry_t mem_d [DEPTH];

  logic [IDX_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [IDX_W-1:0] head_nxt, tail_nxt;
  logic [IDX_W:0]   count_q, count_d;
  commit_t          commit_q, commit_d;

  logic       alloc0, alloc1, ret0, ret1;
  logic [1:0] n_alloc, n_ret;
  logic [1:0] cdb_ok;

  always_comb begin
    head_nxt   = head_q + 1'b1;
    tail_nxt   = tail_q + 1'b1;
    disp_ready = (count_q <= READY_MAX);
    alloc0     = disp_ready & disp_valid[0];
    alloc1     = alloc0 & disp_valid[1];
    ret0       = mem_q[head_q].busy & mem_q[head_q].done;
    ret1       = ret0 & (count_q >= TWO) & mem_q[head_nxt].busy & mem_q[head_nxt].done;
    n_alloc    = {1'b0, alloc0} + {1'b0, alloc1};
    n_ret      = {1'b0, ret0} + {1'b0, ret1};
    // A completion landing on an entry that retires this edge has nothing left to update.
    for (int p = 0; p < 2; p++) begin
      cdb_ok[p] = cdb_valid[p] & mem_q[cdb_tag[p]].busy
                & ~(ret0 & (cdb_tag[p] == head_q))
                & ~(ret1 & (cdb_tag[p] == head_nxt));
    end
  end

  always_comb begin
    mem_d = mem_q;
    if (ret0) begin
      mem_d[head_q].busy = 1'b0;
      mem_d[head_q].done = 1'b0;
    end
    if (ret1) begin
      mem_d[head_nxt].busy = 1'b0;
      mem_d[head_nxt].done = 1'b0;
    end
    // Port 1 is written first so port 0 overrides it on a shared tag.
    if (cdb_ok[1]) begin
      mem_d[cdb_tag[1]].done  = 1'b1;
      mem_d[cdb_tag[1]].value = cdb_value[1];
    end
    if (cdb_ok[0]) begin
      mem_d[cdb_tag[0]].done  = 1'b1;
      mem_d[cdb_tag[0]].value = cdb_value[0];
    end
    if (alloc0) begin
      mem_d[tail_q] = '{busy: 1'b1, done: 1'b0, has_rd: disp_has_rd[0],
                        rd: disp_rd[0], value: '0, pc: disp_pc[0]};
    end
    if (alloc1) begin
      mem_d[tail_nxt] = '{busy: 1'b1, done: 1'b0, has_rd: disp_has_rd[1],
                          rd: disp_rd[1], value: '0, pc: disp_pc[1]};
    end
    if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_d[i].busy = 1'b0;
        mem_d[i].done = 1'b0;
      end
    end
  end

  always_comb begin
    head_d          = head_q + IDX_W'(n_ret);
    tail_d          = tail_q + IDX_W'(n_alloc);
    count_d         = count_q + (IDX_W+1)'(n_alloc) - (IDX_W+1)'(n_ret);
    commit_d        = commit_q;
    commit_d.valid  = {ret1, ret0};
    commit_d.has_rd = {mem_q[head_nxt].has_rd, mem_q[head_q].has_rd};
    commit_d.rd     = {mem_q[head_nxt].rd, mem_q[head_q].rd};
    commit_d.value  = {mem_q[head_nxt].value, mem_q[head_q].value};
    commit_d.pc     = {mem_q[head_nxt].pc, mem_q[head_q].pc};
    if (flush) begin
      head_d         = '0;
      tail_d         = '0;
      count_d        = '0;
      commit_d.valid = 2'b00;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      commit_q <= '0;
    end else begin
      mem_q    <= mem_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
      commit_q <= commit_d;
    end
  end

  assign disp_tag[0]   = tail_q;
  assign disp_tag[1]   = tail_nxt;
  assign commit_valid  = commit_q.valid;
  assign commit_has_rd = commit_q.has_rd;
  assign commit_rd     = commit_q.rd;
  assign commit_value  = commit_q.value;
  assign commit_pc     = commit_q.pc;
  assign count         = count_q;
  assign empty         = (count_q == '0);
  assign full          = (count_q == FULL_CNT);

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based program-order model is
// compared every cycle, plus hand-computed literal checks per scenario.
module tb_reorder_buffer;

  localparam int DEPTH = 16;
  localparam int IDX_W = 4;
  localparam int XLEN  = 32;

  logic                  clk = 1'b0;
  logic                  reset;
  logic [1:0]            disp_valid;
  logic [1:0]            disp_has_rd;
  logic [1:0][4:0]       disp_rd;
  logic [1:0][XLEN-1:0]  disp_pc;
  logic                  disp_ready;
  logic [1:0][IDX_W-1:0] disp_tag;
  logic [1:0]            cdb_valid;
  logic [1:0][IDX_W-1:0] cdb_tag;
  logic [1:0][XLEN-1:0]  cdb_value;
  logic                  flush;
  logic [1:0]            commit_valid;
  logic [1:0]            commit_has_rd;
  logic [1:0][4:0]       commit_rd;
  logic [1:0][XLEN-1:0]  commit_value;
  logic [1:0][XLEN-1:0]  commit_pc;
  logic [IDX_W:0]        count;
  logic                  empty;
  logic                  full;

  int total = 0;
  int bad   = 0;
  bit chk_en = 0;

  reorder_buffer #(.DEPTH(DEPTH), .IDX_W(IDX_W), .XLEN(XLEN)) dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_has_rd(disp_has_rd), .disp_rd(disp_rd),
    .disp_pc(disp_pc), .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .flush(flush), .commit_valid(commit_valid), .commit_has_rd(commit_has_rd),
    .commit_rd(commit_rd), .commit_value(commit_value), .commit_pc(commit_pc),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          tag;
    logic        has_rd;
    logic [4:0]  rd;
    logic [31:0] pc;
    bit          done;
    logic [31:0] value;
  } m_ent_t;

  m_ent_t      mq[$];
  int          m_tail;
  logic [1:0]  exp_cv;
  logic        exp_has [2];
  logic [4:0]  exp_rd  [2];
  logic [31:0] exp_val [2];
  logic [31:0] exp_pc  [2];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Program-order model: the in-flight instructions are simply a queue, oldest first.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_tail = 0;
      exp_cv = 2'b00;
    end else if (flush) begin
      mq.delete();
      m_tail = 0;
      exp_cv = 2'b00;
    end else begin : model_step
      int     n, sz;
      bit     rdy;
      m_ent_t e;
      sz  = mq.size();
      rdy = (sz <= DEPTH - 2);
      n   = 0;
      if (sz >= 1 && mq[0].done) n = 1;
      if (n == 1 && sz >= 2 && mq[1].done) n = 2;
      exp_cv = 2'b00;
      for (int s = 0; s < n; s++) begin
        exp_cv[s]  = 1'b1;
        exp_has[s] = mq[s].has_rd;
        exp_rd[s]  = mq[s].rd;
        exp_val[s] = mq[s].value;
        exp_pc[s]  = mq[s].pc;
      end
      for (int p = 1; p >= 0; p--) begin
        if (cdb_valid[p]) begin
          for (int i = n; i < sz; i++) begin
            if (mq[i].tag == int'(cdb_tag[p])) begin
              e = mq[i];
              e.done  = 1'b1;
              e.value = cdb_value[p];
              mq[i] = e;
            end
          end
        end
      end
      for (int s = 0; s < n; s++) void'(mq.pop_front());
      if (rdy && disp_valid[0]) begin
        for (int s = 0; s < (disp_valid[1] ? 2 : 1); s++) begin
          e.tag    = m_tail;
          e.has_rd = disp_has_rd[s];
          e.rd     = disp_rd[s];
          e.pc     = disp_pc[s];
          e.done   = 1'b0;
          e.value  = '0;
          mq.push_back(e);
          m_tail = (m_tail + 1) % DEPTH;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("m_count", 64'(count), 64'(mq.size()));
      checkOutput("m_ready", 64'(disp_ready), 64'(mq.size() <= DEPTH - 2));
      checkOutput("m_empty", 64'(empty), 64'(mq.size() == 0));
      checkOutput("m_full", 64'(full), 64'(mq.size() == DEPTH));
      checkOutput("m_tag", 64'(disp_tag), 64'({4'((m_tail + 1) % DEPTH), 4'(m_tail)}));
      checkOutput("m_cv", 64'(commit_valid), 64'(exp_cv));
      for (int s = 0; s < 2; s++) begin
        if (exp_cv[s]) begin
          checkOutput("m_has", 64'(commit_has_rd[s]), 64'(exp_has[s]));
          checkOutput("m_rd", 64'(commit_rd[s]), 64'(exp_rd[s]));
          checkOutput("m_val", 64'(commit_value[s]), 64'(exp_val[s]));
          checkOutput("m_pc", 64'(commit_pc[s]), 64'(exp_pc[s]));
        end
      end
    end
  end

  task automatic setIdle();
    disp_valid  = 2'b00;
    disp_has_rd = 2'b00;
    disp_rd     = '0;
    disp_pc     = '0;
    cdb_valid   = 2'b00;
    cdb_tag     = '0;
    cdb_value   = '0;
    flush       = 1'b0;
  endtask

  task automatic setDispatch(input logic [1:0] dv, input logic [1:0] hr, input logic [4:0] rd0,
                             input logic [4:0] rd1, input logic [31:0] pc0, input logic [31:0] pc1);
    disp_valid  = dv;
    disp_has_rd = hr;
    disp_rd[0]  = rd0;
    disp_rd[1]  = rd1;
    disp_pc[0]  = pc0;
    disp_pc[1]  = pc1;
  endtask

  task automatic setCdb(input logic [1:0] cv, input logic [3:0] t0, input logic [3:0] t1,
                        input logic [31:0] v0, input logic [31:0] v1);
    cdb_valid    = cv;
    cdb_tag[0]   = t0;
    cdb_tag[1]   = t1;
    cdb_value[0] = v0;
    cdb_value[1] = v1;
  endtask

  // One clock edge with the currently driven inputs, then back to idle.
  task automatic applyStimulus();
    @(posedge clk);
    #1;
    setIdle();
  endtask

  initial begin
    setIdle();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_en = 1'b1;

    checkOutput("rst_count", 64'(count), 64'd0);
    checkOutput("rst_ready", 64'(disp_ready), 64'd1);
    checkOutput("rst_empty", 64'(empty), 64'd1);
    checkOutput("rst_full", 64'(full), 64'd0);
    checkOutput("rst_tag", 64'(disp_tag), 64'h10);
    checkOutput("rst_cv", 64'(commit_valid), 64'd0);

    setDispatch(2'b11, 2'b11, 5'd3, 5'd4, 32'h100, 32'h104);
    applyStimulus();
    checkOutput("t1_count", 64'(count), 64'd2);
    setCdb(2'b11, 4'd0, 4'd1, 32'hAA, 32'hBB);
    applyStimulus();
    checkOutput("t1_nocommit", 64'(commit_valid), 64'd0);
    applyStimulus();
    checkOutput("t1_cv", 64'(commit_valid), 64'd3);
    checkOutput("t1_rd", 64'(commit_rd), 64'({5'd4, 5'd3}));
    checkOutput("t1_val", 64'(commit_value), {32'hBB, 32'hAA});
    checkOutput("t1_pc", 64'(commit_pc), {32'h104, 32'h100});
    checkOutput("t1_count0", 64'(count), 64'd0);

    // Out-of-order completion must still retire in program order.
    flush = 1'b1;
    applyStimulus();
    setDispatch(2'b11, 2'b11, 5'd5, 5'd6, 32'h200, 32'h204);
    applyStimulus();
    setDispatch(2'b01, 2'b01, 5'd7, 5'd0, 32'h208, 32'h0);
    applyStimulus();
    setCdb(2'b01, 4'd2, 4'd0, 32'h22, 32'h0);
    applyStimulus();
    setCdb(2'b01, 4'd1, 4'd0, 32'h11, 32'h0);
    applyStimulus();
    checkOutput("t2_wait1", 64'(commit_valid), 64'd0);
    setCdb(2'b01, 4'd0, 4'd0, 32'h10, 32'h0);
    applyStimulus();
    checkOutput("t2_wait2", 64'(commit_valid), 64'd0);
    applyStimulus();
    checkOutput("t2_cv01", 64'(commit_valid), 64'd3);
    checkOutput("t2_pc01", 64'(commit_pc), {32'h204, 32'h200});
    checkOutput("t2_val01", 64'(commit_value), {32'h11, 32'h10});
    applyStimulus();
    checkOutput("t2_cv2", 64'(commit_valid), 64'd1);
    checkOutput("t2_pc2", 64'(commit_pc[0]), 64'h208);
    checkOutput("t2_val2", 64'(commit_value[0]), 64'h22);

    flush = 1'b1;
    applyStimulus();
    for (int i = 0; i < 8; i++) begin
      setDispatch(2'b11, 2'b01, 5'(2 * i), 5'(2 * i + 1), 32'h300 + 32'(8 * i), 32'h304 + 32'(8 * i));
      applyStimulus();
      if (i == 6) begin
        checkOutput("t3_c14", 64'(count), 64'd14);
        checkOutput("t3_rdy14", 64'(disp_ready), 64'd1);
      end
    end
    checkOutput("t3_c16", 64'(count), 64'd16);
    checkOutput("t3_full", 64'(full), 64'd1);
    checkOutput("t3_rdy16", 64'(disp_ready), 64'd0);
    setDispatch(2'b11, 2'b11, 5'd1, 5'd2, 32'h900, 32'h904);
    applyStimulus();
    checkOutput("t3_ignored", 64'(count), 64'd16);
    setCdb(2'b01, 4'd0, 4'd0, 32'h30, 32'h0);
    applyStimulus();
    setDispatch(2'b11, 2'b11, 5'd1, 5'd2, 32'h900, 32'h904);
    setCdb(2'b01, 4'd1, 4'd0, 32'h31, 32'h0);
    applyStimulus();
    checkOutput("t3_c15", 64'(count), 64'd15);
    checkOutput("t3_rdy15", 64'(disp_ready), 64'd0);
    checkOutput("t3_notfull", 64'(full), 64'd0);
    setDispatch(2'b11, 2'b11, 5'd1, 5'd2, 32'h900, 32'h904);
    applyStimulus();
    checkOutput("t3_c14b", 64'(count), 64'd14);
    checkOutput("t3_rdy", 64'(disp_ready), 64'd1);
    checkOutput("t3_wrap", 64'(disp_tag), 64'h10);
    setDispatch(2'b11, 2'b11, 5'd8, 5'd9, 32'hA00, 32'hA04);
    applyStimulus();
    checkOutput("t3_refill", 64'(count), 64'd16);

    flush = 1'b1;
    applyStimulus();
    setDispatch(2'b01, 2'b01, 5'd1, 5'd0, 32'h400, 32'h0);
    applyStimulus();
    setDispatch(2'b10, 2'b11, 5'd2, 5'd3, 32'h404, 32'h408);
    applyStimulus();
    checkOutput("t4_count", 64'(count), 64'd1);
    checkOutput("t4_tag", 64'(disp_tag), 64'h21);

    flush = 1'b1;
    applyStimulus();
    for (int i = 0; i < 3; i++) begin
      setDispatch((i == 2) ? 2'b01 : 2'b11, 2'b11, 5'(i + 10), 5'(i + 20), 32'h500 + 32'(8 * i), 32'h504 + 32'(8 * i));
      applyStimulus();
    end
    checkOutput("t5_c5", 64'(count), 64'd5);
    setCdb(2'b01, 4'd0, 4'd0, 32'h50, 32'h0);
    applyStimulus();
    flush = 1'b1;
    setCdb(2'b01, 4'd1, 4'd0, 32'h51, 32'h0);
    setDispatch(2'b11, 2'b11, 5'd1, 5'd2, 32'h600, 32'h604);
    applyStimulus();
    checkOutput("t5_count", 64'(count), 64'd0);
    checkOutput("t5_empty", 64'(empty), 64'd1);
    checkOutput("t5_cv", 64'(commit_valid), 64'd0);
    checkOutput("t5_tag", 64'(disp_tag), 64'h10);
    setCdb(2'b01, 4'd3, 4'd0, 32'h53, 32'h0);
    applyStimulus();
    applyStimulus();
    checkOutput("t5_stale_c", 64'(count), 64'd0);
    checkOutput("t5_stale_cv", 64'(commit_valid), 64'd0);

    // Reset mid-cycle must clear state without waiting for a clock edge.
    for (int i = 0; i < 4; i++) begin
      setDispatch(2'b11, 2'b11, 5'(i), 5'(i + 4), 32'h700 + 32'(8 * i), 32'h704 + 32'(8 * i));
      applyStimulus();
    end
    setCdb(2'b11, 4'd0, 4'd1, 32'h70, 32'h71);
    applyStimulus();
    applyStimulus();
    checkOutput("t6_c6", 64'(count), 64'd6);
    checkOutput("t6_cv", 64'(commit_valid), 64'd3);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("t6_async_c", 64'(count), 64'd0);
    checkOutput("t6_async_cv", 64'(commit_valid), 64'd0);
    checkOutput("t6_async_empty", 64'(empty), 64'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    applyStimulus();
    checkOutput("t6_after", 64'(disp_tag), 64'h10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
